ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs or 0xFF reset) from the Apple-1 core to the attached keyboard over the same two open-collector lines the keyboard receiver listens on. It generates the request-to-send sequence, shifts the frame out on device-generated clock edges, checks the device ACK and reports completion. It sits beside the keyboard receiver; `busy` gates the receiver so it ignores the host-driven frame.

## Interface
Parameters:
- `CLK_INHIBIT_CYCLES`, 840: cycles the clock line is held low before the start bit (120 µs at 7 MHz).
- `START_HOLD_CYCLES`, 35: cycles both lines are held low before the clock is released.
- `TIMEOUT_CYCLES`, 14000: watchdog limit between device clock falling edges (2 ms).

Ports:
- `clk7`  in  1  7 MHz master clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  8  byte to send; sampled when `tx_start` is accepted.
- `tx_start`  in  1  one-cycle request; ignored while `busy`=1.
- `ps2_clk`  in  1  PS/2 clock line as seen at the pin (asynchronous).
- `ps2_din`  in  1  PS/2 data line as seen at the pin (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull clock line low; 0 = release.
- `ps2_dat_oe`  out  1  1 = pull data line low; 0 = release.
- `busy`  out  1  high from acceptance to `done`.
- `done`  out  1  one-cycle completion pulse.
- `ack_err`  out  1  valid with `done`: device did not ACK.
- `timeout`  out  1  valid with `done`: watchdog expired.

## Operation
- Inputs pass through a 2-flop synchronizer, then the optional filter. A falling edge is filtered clk previous=1, current=0.
- Frame: start (0), D0..D7 LSB first, odd parity (`~^tx_data`), stop (1). ACK is device-driven.
- States:
  - IDLE: all outputs 0. On `tx_start`, latch the shift register {stop, parity, tx_data} and go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for `CLK_INHIBIT_CYCLES`, then go to START.
  - START: `ps2_clk_oe`=1, `ps2_dat_oe`=1 for `START_HOLD_CYCLES`. Then release the clock, clear `bitcnt`=0 and the watchdog, and go to SHIFT.
  - SHIFT: on each falling edge, `ps2_dat_oe` = ~shift[0], shift right, `bitcnt`++. After the 10th edge (the stop bit is driven as a release), go to ACK.
  - ACK: on the 11th falling edge, sample synced data. 0 = ACK ok; 1 sets the `ack_err` latch. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clk=1 and data=1. Then pulse `done` and return to IDLE.
- The watchdog counts in SHIFT, ACK and WAIT_IDLE and clears on every falling edge. When it reaches `TIMEOUT_CYCLES`, the block releases both lines, pulses `done` with `timeout`=1 and returns to IDLE.
- `ack_err` and `timeout` hold their values until the next accepted `tx_start`, which clears them.

## Timing
- Reset: every output is 0 and the state is IDLE. Asserting reset mid-frame releases both lines immediately (asynchronously).
- `tx_start` accepted at cycle N: `busy`=1 and `ps2_clk_oe`=1 at N+1.
- `ps2_dat_oe` rises at N+1+`CLK_INHIBIT_CYCLES`. `ps2_clk_oe` falls `START_HOLD_CYCLES` later.
- Data update lands one cycle after the falling edge is detected. Edge detection lags the pin by 2 cycles, or by 2+8 cycles with the filter.
- `done` is high for exactly one cycle, and `busy` falls in the same cycle.
- `tx_start` arriving during `done` is ignored. A request is accepted only when `busy`=0.
- A falling edge that arrives in the same cycle the watchdog expires counts as an edge: the watchdog clears and no timeout occurs.

## Configuration
- `PS2_TX_FILTER_EN` defined: synced clk and data each update their filtered value only after 8 consecutive equal samples. This rejects glitches shorter than 8 cycles.
- Not defined: the filtered value equals the 2-flop synced value, with no added latency.

## Test plan
Bench overrides: `CLK_INHIBIT_CYCLES`=16, `START_HOLD_CYCLES`=4, `TIMEOUT_CYCLES`=200. The device model uses a 40-cycle clock period.
- Send 0xED with the device ACKing -> bits sampled on rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1. `done` pulses with `ack_err`=0 and `timeout`=0.
- Send 0x01 -> parity bit 0. Send 0x00 -> parity 1. Both complete cleanly.
- Device holds data high at the 11th edge -> `done` with `ack_err`=1; both `oe` outputs are 0 afterward.
- Device never clocks after the clock is released -> `done` with `timeout`=1 at release+200 cycles; lines released.
- `tx_start` pulsed mid-frame with 0x55 -> ignored; the original byte completes. Reset asserted in SHIFT -> `ps2_clk_oe`=`ps2_dat_oe`=`busy`=0 in the same cycle.
- With `PS2_TX_FILTER_EN`: a 3-cycle low glitch on clk during SHIFT -> no bit advance and the frame completes correctly. Without the macro, the same glitch shifts an extra bit.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one byte to the keyboard: holds the clock low (inhibit), pulls data
// low and releases the clock (request-to-send), then shifts start/D0..D7/
// parity/stop on device-generated falling clock edges, samples the device ACK
// and reports completion. A watchdog aborts the frame if the device stops
// clocking.
//
// Optional build macro: PS2_TX_FILTER_EN -- adds an 8-sample glitch filter on
// the synchronized clock and data lines.
//
// Ports:
//   clk7        7 MHz master clock
//   rst_n       asynchronous active-low reset
//   tx_data     byte to send, sampled when tx_start is accepted
//   tx_start    one-cycle request, accepted only while idle
//   ps2_clk     PS/2 clock line at the pin (asynchronous)
//   ps2_din     PS/2 data line at the pin (asynchronous)
//   ps2_clk_oe  1 = pull clock line low
//   ps2_dat_oe  1 = pull data line low
//   busy        high from acceptance until done
//   done        one-cycle completion pulse
//   ack_err     device did not ACK (held until next accepted request)
//   timeout     watchdog expired (held until next accepted request)

module ps2_host_tx #(
    parameter int CLK_INHIBIT_CYCLES = 840,
    parameter int START_HOLD_CYCLES  = 35,
    parameter int TIMEOUT_CYCLES     = 14000
) (
    input  logic       clk7,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int PH_MAX = (CLK_INHIBIT_CYCLES > START_HOLD_CYCLES) ?
                            CLK_INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state, state_d;
    logic [PH_W-1:0] ph_cnt, ph_cnt_d;
    logic [WD_W-1:0] wd_cnt, wd_cnt_d;
    logic [3:0]      bitcnt, bitcnt_d;
    logic [9:0]      shift, shift_d;
    logic            clk_oe_d, dat_oe_d, done_d, ack_err_d, timeout_d;

    // Two-flop synchronizers; idle lines are high, so reset to 1.
    logic [1:0] clk_sync, dat_sync;
    logic       clk_f, dat_f, clk_prev, fall;

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_din};
        end
    end

`ifdef PS2_TX_FILTER_EN
    // Filtered value follows the synced value only after 8 consecutive
    // differing samples; any return to the filtered value restarts the count.
    logic [2:0] clk_cnt, dat_cnt;

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            clk_f   <= 1'b1;
            dat_f   <= 1'b1;
            clk_cnt <= '0;
            dat_cnt <= '0;
        end else begin
            if (clk_sync[1] == clk_f) begin
                clk_cnt <= '0;
            end else if (clk_cnt == 3'd7) begin
                clk_f   <= clk_sync[1];
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 3'd1;
            end
            if (dat_sync[1] == dat_f) begin
                dat_cnt <= '0;
            end else if (dat_cnt == 3'd7) begin
                dat_f   <= dat_sync[1];
                dat_cnt <= '0;
            end else begin
                dat_cnt <= dat_cnt + 3'd1;
            end
        end
    end
`else
    assign clk_f = clk_sync[1];
    assign dat_f = dat_sync[1];
`endif

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) clk_prev <= 1'b1;
        else        clk_prev <= clk_f;
    end

    assign fall = clk_prev & ~clk_f;
    assign busy = (state != IDLE);

    always_ff @(posedge clk7 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ph_cnt     <= '0;
            wd_cnt     <= '0;
            bitcnt     <= '0;
            shift      <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_d;
            ph_cnt     <= ph_cnt_d;
            wd_cnt     <= wd_cnt_d;
            bitcnt     <= bitcnt_d;
            shift      <= shift_d;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            done       <= done_d;
            ack_err    <= ack_err_d;
            timeout    <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state;
        ph_cnt_d  = ph_cnt;
        wd_cnt_d  = wd_cnt;
        bitcnt_d  = bitcnt;
        shift_d   = shift;
        clk_oe_d  = ps2_clk_oe;
        dat_oe_d  = ps2_dat_oe;
        done_d    = 1'b0;
        ack_err_d = ack_err;
        timeout_d = timeout;

        case (state)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                // The done cycle already shows busy=0; a request there is dropped.
                if (tx_start && !done) begin
                    shift_d   = {1'b1, ~^tx_data, tx_data};
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                    ph_cnt_d  = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (ph_cnt == PH_W'(CLK_INHIBIT_CYCLES - 1)) begin
                    ph_cnt_d = '0;
                    dat_oe_d = 1'b1;
                    state_d  = START;
                end else begin
                    ph_cnt_d = ph_cnt + 1'b1;
                end
            end
            START: begin
                if (ph_cnt == PH_W'(START_HOLD_CYCLES - 1)) begin
                    clk_oe_d = 1'b0;
                    bitcnt_d = '0;
                    wd_cnt_d = '0;
                    state_d  = SHIFT;
                end else begin
                    ph_cnt_d = ph_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (fall) begin
                    dat_oe_d = ~shift[0];
                    shift_d  = {1'b1, shift[9:1]};
                    bitcnt_d = bitcnt + 4'd1;
                    if (bitcnt == 4'd9) state_d = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    if (dat_f) ack_err_d = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_f && dat_f) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog overrides the state decisions above; a falling edge in the
        // expiry cycle wins over the timeout.
        if (state == SHIFT || state == ACK || state == WAIT_IDLE) begin
            if (fall) begin
                wd_cnt_d = '0;
            end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_cnt_d  = '0;
                clk_oe_d  = 1'b0;
                dat_oe_d  = 1'b0;
                done_d    = 1'b1;
                timeout_d = 1'b1;
                state_d   = IDLE;
            end else begin
                wd_cnt_d = wd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    logic       clk7 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_start = 1'b0;
    logic       ps2_clk, ps2_din;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout;
    logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0, glitch = 1'b0;

    // Open-collector lines with pull-ups.
    assign ps2_clk = ~ps2_clk_oe & ~dev_clk_low & ~glitch;
    assign ps2_din = ~ps2_dat_oe & ~dev_dat_low;

    ps2_host_tx #(
        .CLK_INHIBIT_CYCLES(16),
        .START_HOLD_CYCLES (4),
        .TIMEOUT_CYCLES    (200)
    ) dut (
        .clk7      (clk7),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .ps2_clk   (ps2_clk),
        .ps2_din   (ps2_din),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .timeout   (timeout)
    );

    always #5 clk7 = ~clk7;

    int unsigned cyc = 0;
    always @(posedge clk7) cyc <= cyc + 1;

    typedef struct {
        logic        exp_ack_err;
        logic        exp_timeout;
        logic        chk_bits;
        logic [10:0] exp_bits;
    } exp_t;

    exp_t        sb[$];
    logic [10:0] dev_bits = '0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic ae, input logic to, input logic cb, input logic [10:0] bits);
        exp_t e;
        e.exp_ack_err = ae;
        e.exp_timeout = to;
        e.chk_bits    = cb;
        e.exp_bits    = bits;
        return e;
    endfunction

    // Completion monitor: pops the scoreboard on every done pulse.
    int unsigned rel_cyc = 0;
    logic        clk_oe_prev = 1'b0;
    exp_t        got_e;
    always @(negedge clk7) begin
        if (clk_oe_prev && !ps2_clk_oe) rel_cyc = cyc;
        clk_oe_prev = ps2_clk_oe;
        if (done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                got_e = sb.pop_front();
                check("ack_err", ack_err, got_e.exp_ack_err);
                check("timeout", timeout, got_e.exp_timeout);
                check("busy_at_done", busy, 0);
                check("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
                if (got_e.chk_bits) check("frame_bits", dev_bits, got_e.exp_bits);
                if (got_e.exp_timeout) check("timeout_latency", cyc - rel_cyc, 200);
            end
        end
    end

    // Device model: waits for request-to-send, then clocks 11 bits at a
    // 40-cycle period, sampling data just before each rising edge.
    task automatic device(input bit do_clock, input bit do_ack, input int glitch_k);
        int n;
        n = 0;
        while (!ps2_clk_oe && n < 500) begin @(negedge clk7); n++; end
        if (n >= 500) check("dev_wait_inhibit", 0, 1);
        n = 0;
        while (!(!ps2_clk_oe && !ps2_din) && n < 500) begin @(negedge clk7); n++; end
        if (n >= 500) check("dev_wait_rts", 0, 1);
        if (!do_clock) return;
        repeat (10) @(negedge clk7);
        dev_bits[0] = ps2_din;
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk7);
            if (k <= 10) dev_bits[k] = ps2_din;
            dev_clk_low = 1'b0;
            if (k == glitch_k) begin
                repeat (5) @(negedge clk7);
                glitch = 1'b1;
                repeat (3) @(negedge clk7);
                glitch = 1'b0;
                repeat (12) @(negedge clk7);
            end else if (k == 10 && do_ack) begin
                repeat (5) @(negedge clk7);
                dev_dat_low = 1'b1;
                repeat (15) @(negedge clk7);
            end else begin
                repeat (20) @(negedge clk7);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input exp_t e, input bit timing);
        @(negedge clk7);
        tx_data  = d;
        tx_start = 1'b1;
        sb.push_back(e);
        @(negedge clk7);
        tx_start = 1'b0;
        if (timing) begin
            check("accept_n1", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b110);
            repeat (15) @(negedge clk7);
            check("dat_oe_before_inhibit_end", ps2_dat_oe, 0);
            @(negedge clk7);
            check("dat_oe_rise", {ps2_clk_oe, ps2_dat_oe}, 2'b11);
            repeat (3) @(negedge clk7);
            check("clk_oe_hold", ps2_clk_oe, 1);
            @(negedge clk7);
            check("clk_oe_release", {ps2_clk_oe, ps2_dat_oe}, 2'b01);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin @(negedge clk7); n++; end
        if (n >= 3000) check("scoreboard_drain", sb.size(), 0);
        repeat (5) @(negedge clk7);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got=expired expected=finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    logic [10:0] fr, gx;
    logic        g_ack;

    initial begin
        repeat (3) @(negedge clk7);
        check("reset_outputs", {busy, ps2_clk_oe, ps2_dat_oe, done, ack_err, timeout}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk7);

        // 0xED, ACK ok, with request-to-send timing checks.
        fork
            send(8'hED, mk(0, 0, 1, {1'b1, 1'b1, 8'hED, 1'b0}), 1);
            device(1, 1, 0);
        join
        drain();

        // 0x01 -> parity 0.
        fork
            send(8'h01, mk(0, 0, 1, {1'b1, 1'b0, 8'h01, 1'b0}), 0);
            device(1, 1, 0);
        join
        drain();

        // No ACK from device.
        fork
            send(8'hA5, mk(1, 0, 1, {1'b1, 1'b1, 8'hA5, 1'b0}), 0);
            device(1, 0, 0);
        join
        drain();

        // Device never clocks -> watchdog.
        fork
            send(8'h3C, mk(0, 1, 0, '0), 0);
            device(0, 0, 0);
        join
        drain();

        // Request mid-frame is ignored.
        fork
            send(8'h96, mk(0, 0, 1, {1'b1, 1'b1, 8'h96, 1'b0}), 0);
            device(1, 1, 0);
            begin
                repeat (150) @(negedge clk7);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk7);
                tx_start = 1'b0;
            end
        join
        drain();
        check("no_extra_frame", busy, 0);

        // Request in the done cycle is ignored.
        fork
            send(8'h01, mk(0, 0, 1, {1'b1, 1'b0, 8'h01, 1'b0}), 0);
            device(1, 1, 0);
            begin
                int n;
                n = 0;
                while (!done && n < 3000) begin @(negedge clk7); n++; end
                if (n >= 3000) check("wait_done", 0, 1);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                @(negedge clk7);
                tx_start = 1'b0;
                @(negedge clk7);
                check("start_in_done_ignored", busy, 0);
            end
        join
        drain();

        // 3-cycle low glitch on the clock during SHIFT.
        fr = {1'b1, 1'b1, 8'hED, 1'b0};
`ifdef PS2_TX_FILTER_EN
        gx    = fr;
        g_ack = 1'b0;
`else
        // The glitch counts as an extra edge after device clock 3, so every
        // later device sample sees the host one bit ahead and the host takes
        // its ACK sample at device clock 10 while data is still released.
        for (int k = 0; k <= 10; k++) begin
            int j;
            j = (k > 3) ? ((k + 1 > 10) ? 10 : k + 1) : k;
            gx[k] = fr[j];
        end
        g_ack = 1'b1;
`endif
        fork
            send(8'hED, mk(g_ack, 0, 1, gx), 0);
            device(1, 1, 3);
        join
        drain();

        // Reset asserted in SHIFT releases everything at once.
        send(8'h12, mk(0, 0, 0, '0), 0);
        begin
            int n;
            n = 0;
            while (ps2_clk_oe && n < 200) begin @(negedge clk7); n++; end
            while (!ps2_clk_oe && busy && n < 10) begin @(negedge clk7); n++; end
        end
        check("shift_start_bit_driven", {busy, ps2_clk_oe, ps2_dat_oe}, 3'b101);
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame", {busy, ps2_clk_oe, ps2_dat_oe}, 0);
        sb.delete();
        repeat (2) @(negedge clk7);
        rst_n = 1'b1;
        repeat (3) @(negedge clk7);

        // 0x00 -> parity 1, clean frame after reset.
        fork
            send(8'h00, mk(0, 0, 1, {1'b1, 1'b1, 8'h00, 1'b0}), 0);
            device(1, 1, 0);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
